// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the three requester ports (Icache, Dcache, uncached), the
//   bus-controller port and the arbiter debug taps into one interface.
//   Modports:
//     slave  - the arbiter: takes requests and bus responses, drives data back
//     master - the environment: the caches/EX stage plus the bus controller
//   Signals keep their _i/_o suffixes as seen from the arbiter.
//
//   Handshake semantics (all requesters): a requester raises *_req_i and holds
//   it, together with its address/write/data fields, until it sees the
//   matching one-cycle *_ready_o pulse, and drops it at the following clock
//   edge. On the bus side, bus_req_o is held with stable address/write/data
//   until bus_ack_i is seen high at a clock edge; each ack completes one beat.
interface mem_bus_arbiter_if #(
  parameter int LINE_WORDS = 4,
  parameter int MAX_WAIT   = 8
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int AW = $clog2(MAX_WAIT + 1);

  logic          ic_req_i;
  logic [31:0]   ic_addr_i;
  logic          ic_flush_i;
  logic          ic_rvalid_o;
  logic [31:0]   ic_rdata_o;
  logic [BW-1:0] ic_beat_o;
  logic          ic_ready_o;

  logic          dc_req_i;
  logic          dc_we_i;
  logic [31:0]   dc_addr_i;
  logic [31:0]   dc_wdata_i;
  logic          dc_rvalid_o;
  logic [31:0]   dc_rdata_o;
  logic          dc_ready_o;

  logic          un_req_i;
  logic          un_we_i;
  logic [31:0]   un_addr_i;
  logic [31:0]   un_wdata_i;
  logic [31:0]   un_rdata_o;
  logic          un_ready_o;

  logic          bus_req_o;
  logic          bus_we_o;
  logic [31:0]   bus_addr_o;
  logic [31:0]   bus_wdata_o;
  logic [31:0]   bus_rdata_i;
  logic          bus_ack_i;
  logic [1:0]    grant_o;

  logic [2:0]    dbg_state_o;
  logic [AW-1:0] dbg_age_o;

  modport slave (
    input  ic_req_i, ic_addr_i, ic_flush_i,
    output ic_rvalid_o, ic_rdata_o, ic_beat_o, ic_ready_o,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    output dc_rvalid_o, dc_rdata_o, dc_ready_o,
    input  un_req_i, un_we_i, un_addr_i, un_wdata_i,
    output un_rdata_o, un_ready_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i,
    output grant_o, dbg_state_o, dbg_age_o
  );

  modport master (
    output ic_req_i, ic_addr_i, ic_flush_i,
    input  ic_rvalid_o, ic_rdata_o, ic_beat_o, ic_ready_o,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    input  dc_rvalid_o, dc_rdata_o, dc_ready_o,
    output un_req_i, un_we_i, un_addr_i, un_wdata_i,
    input  un_rdata_o, un_ready_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i,
    input  grant_o, dbg_state_o, dbg_age_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single bus-controller port between Icache line refills,
//   Dcache refill/write-back bursts and single-beat uncached accesses.
//   Fixed priority uncached > Dcache > Icache, except that an Icache request
//   which has lost MAX_WAIT arbitrations is promoted to the top.
//   Ports:
//     clk     - clock
//     rst     - asynchronous reset, active-high
//     bus_if  - mem_bus_arbiter_if.slave: requester ports, bus-controller
//               port, grant_o and debug taps (dbg_state_o, dbg_age_o)
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_bus_arbiter_if.slave       bus_if
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_WORDS - 1);
  localparam logic [AW-1:0] AGE_MAX   = AW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_I = 3'd1,
    GNT_D = 3'd2,
    GNT_U = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e        state_q;
  logic [BW-1:0] beat_q;
  logic [AW-1:0] age_q;
  logic [AW-1:0] age_d;
  logic          discard_q;
  logic          bus_req_q;
  logic [1:0]    grant_q;
  logic          ic_ready_q;
  logic          dc_ready_q;
  logic          un_ready_q;

  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_we;

  // Saturating increment used when the Icache loses an arbitration.
  assign age_d = (age_q == AGE_MAX) ? age_q : age_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      age_q      <= '0;
      discard_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      grant_q    <= 2'd0;
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      un_ready_q <= 1'b0;
    end else begin
      // Ready outputs are one-cycle pulses: only the burst-end edge sets one.
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      un_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.ic_req_i && (age_q == AGE_MAX)) begin
            state_q   <= GNT_I;
            grant_q   <= 2'd1;
            bus_req_q <= 1'b1;
            age_q     <= '0;
          end else if (bus_if.un_req_i) begin
            state_q   <= GNT_U;
            grant_q   <= 2'd3;
            bus_req_q <= 1'b1;
            if (bus_if.ic_req_i) age_q <= age_d;
          end else if (bus_if.dc_req_i) begin
            state_q   <= GNT_D;
            grant_q   <= 2'd2;
            bus_req_q <= 1'b1;
            if (bus_if.ic_req_i) age_q <= age_d;
          end else if (bus_if.ic_req_i) begin
            state_q   <= GNT_I;
            grant_q   <= 2'd1;
            bus_req_q <= 1'b1;
            age_q     <= '0;
          end
        end
        GNT_I: begin
          // A flush cannot cancel the bus burst; it only hides the result.
          if (bus_if.ic_flush_i) discard_q <= 1'b1;
          if (bus_if.bus_ack_i) begin
            if (beat_q == BEAT_LAST) begin
              state_q    <= RESP;
              beat_q     <= '0;
              bus_req_q  <= 1'b0;
              grant_q    <= 2'd0;
              ic_ready_q <= ~(discard_q | bus_if.ic_flush_i);
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        GNT_D: begin
          if (bus_if.bus_ack_i) begin
            if (beat_q == BEAT_LAST) begin
              state_q    <= RESP;
              beat_q     <= '0;
              bus_req_q  <= 1'b0;
              grant_q    <= 2'd0;
              dc_ready_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        GNT_U: begin
          if (bus_if.bus_ack_i) begin
            state_q    <= RESP;
            beat_q     <= '0;
            bus_req_q  <= 1'b0;
            grant_q    <= 2'd0;
            un_ready_q <= 1'b1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          discard_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus-side mux; everything reads zero outside a grant.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state_q)
      GNT_I: bus_addr = {bus_if.ic_addr_i[31:BW+2], beat_q, 2'b00};
      GNT_D: begin
        bus_addr  = {bus_if.dc_addr_i[31:BW+2], beat_q, 2'b00};
        bus_wdata = bus_if.dc_wdata_i;
        bus_we    = bus_if.dc_we_i;
      end
      GNT_U: begin
        bus_addr  = bus_if.un_addr_i;
        bus_wdata = bus_if.un_wdata_i;
        bus_we    = bus_if.un_we_i;
      end
      default: ;
    endcase
  end

  // Line offset bits of the burst addresses are replaced by the beat counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_if.ic_addr_i[BW+1:0], bus_if.dc_addr_i[BW+1:0]};

  assign bus_if.bus_req_o   = bus_req_q;
  assign bus_if.bus_addr_o  = bus_addr;
  assign bus_if.bus_wdata_o = bus_wdata;
  assign bus_if.bus_we_o    = bus_we;
  assign bus_if.grant_o     = grant_q;

  assign bus_if.ic_rvalid_o = (state_q == GNT_I) & bus_if.bus_ack_i
                              & ~discard_q & ~bus_if.ic_flush_i;
  assign bus_if.ic_rdata_o  = ((state_q == GNT_I) & bus_if.bus_ack_i) ? bus_if.bus_rdata_i : '0;
  assign bus_if.ic_beat_o   = beat_q;
  assign bus_if.ic_ready_o  = ic_ready_q;

  assign bus_if.dc_rvalid_o = (state_q == GNT_D) & bus_if.bus_ack_i & ~bus_if.dc_we_i;
  assign bus_if.dc_rdata_o  = ((state_q == GNT_D) & bus_if.bus_ack_i) ? bus_if.bus_rdata_i : '0;
  assign bus_if.dc_ready_o  = dc_ready_q;

  assign bus_if.un_rdata_o  = ((state_q == GNT_U) & bus_if.bus_ack_i) ? bus_if.bus_rdata_i : '0;
  assign bus_if.un_ready_o  = un_ready_q;

  assign bus_if.dbg_state_o = state_q;
  assign bus_if.dbg_age_o   = age_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Table of single-arbitration vectors, hand-written multi-cycle sequences
//   and randomized traffic, all checked against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int LW = 4;
  localparam int MW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.LINE_WORDS(LW), .MAX_WAIT(MW)) bif ();
  mem_bus_arbiter #(.LINE_WORDS(LW), .MAX_WAIT(MW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];

  // requester-side stimulus state (applied at the negedge by tick)
  bit          ic_r, dc_r, un_r, dc_w, un_w, flush_n;
  logic [31:0] ic_a, dc_a, un_a, un_wd, dc_wbase;
  int          rate_ic, rate_dc, rate_un;
  int          ack_pct, stall, stall_cnt;
  bit          ic_seen, dc_seen, un_seen;
  bit          tick_rose, last_ack, prev_req;
  logic [2:0]  arb_reqs;

  // transaction-level model state
  int m_ph;    // 0 waiting, 1 on the bus, 2 completion cycle
  int m_own;   // 1 Icache, 2 Dcache, 3 uncached
  int m_beat;
  int m_age;   // arbitrations lost by a pending Icache request
  bit m_disc;
  bit p_ic, p_dc, p_un, p_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic chk_all_zero();
    chk1("z_bus_req", bif.bus_req_o, 1'b0);
    chk("z_grant", 32'(bif.grant_o), 0);
    chk1("z_ic_ready", bif.ic_ready_o, 1'b0);
    chk1("z_dc_ready", bif.dc_ready_o, 1'b0);
    chk1("z_un_ready", bif.un_ready_o, 1'b0);
    chk1("z_ic_rvalid", bif.ic_rvalid_o, 1'b0);
    chk1("z_dc_rvalid", bif.dc_rvalid_o, 1'b0);
    chk("z_ic_rdata", bif.ic_rdata_o, 0);
    chk("z_dc_rdata", bif.dc_rdata_o, 0);
    chk("z_un_rdata", bif.un_rdata_o, 0);
    chk("z_bus_addr", bif.bus_addr_o, 0);
    chk("z_bus_wdata", bif.bus_wdata_o, 0);
    chk1("z_bus_we", bif.bus_we_o, 1'b0);
    chk("z_beat", 32'(bif.ic_beat_o), 0);
    chk("z_state", 32'(bif.dbg_state_o), 0);
    chk("z_age", 32'(bif.dbg_age_o), 0);
  endtask

  // Arbitration and burst rules, expressed per cycle from the requests that
  // were presented in the previous cycle.
  task automatic model_step(input bit ack, input bit f_now);
    int w;
    bit busy;
    logic [31:0] line_mask;
    line_mask = ~32'(LW * 4 - 1);
    case (m_ph)
      0: if (p_ic || p_dc || p_un) begin
        if (p_ic && m_age == MW) w = 1;
        else if (p_un)           w = 3;
        else if (p_dc)           w = 2;
        else                     w = 1;
        if (w == 1) m_age = 0;
        else if (p_ic && m_age < MW) m_age++;
        m_ph = 1; m_own = w; m_beat = 0;
      end
      1: if (p_ack) begin
        if (m_own == 3 || m_beat == LW - 1) begin m_ph = 2; m_beat = 0; end
        else m_beat++;
      end
      default: begin m_ph = 0; m_disc = 0; end
    endcase
    busy = (m_ph == 1);
    chk1("bus_req", bif.bus_req_o, busy);
    chk("grant", 32'(bif.grant_o), busy ? m_own : 0);
    chk1("ic_ready", bif.ic_ready_o, m_ph == 2 && m_own == 1 && !m_disc);
    chk1("dc_ready", bif.dc_ready_o, m_ph == 2 && m_own == 2);
    chk1("un_ready", bif.un_ready_o, m_ph == 2 && m_own == 3);
    chk("beat", 32'(bif.ic_beat_o), busy ? m_beat : 0);
    chk("age", 32'(bif.dbg_age_o), m_age);
    chk1("ic_rvalid", bif.ic_rvalid_o, busy && m_own == 1 && ack && !m_disc && !f_now);
    chk1("dc_rvalid", bif.dc_rvalid_o, busy && m_own == 2 && ack && !dc_w);
    if (busy) begin
      case (m_own)
        1: begin
          chk("ic_addr", bif.bus_addr_o, (ic_a & line_mask) | 32'(m_beat * 4));
          chk1("ic_we", bif.bus_we_o, 1'b0);
          if (ack) chk("ic_rdata", bif.ic_rdata_o, bif.bus_rdata_i);
        end
        2: begin
          chk("dc_addr", bif.bus_addr_o, (dc_a & line_mask) | 32'(m_beat * 4));
          chk1("dc_we", bif.bus_we_o, dc_w);
          chk("dc_wdata", bif.bus_wdata_o, dc_wbase + 32'(m_beat));
          if (ack && !dc_w) chk("dc_rdata", bif.dc_rdata_o, bif.bus_rdata_i);
        end
        default: begin
          chk("un_addr", bif.bus_addr_o, un_a);
          chk1("un_we", bif.bus_we_o, un_w);
          chk("un_wdata", bif.bus_wdata_o, un_wd);
          if (ack) chk("un_rdata", bif.un_rdata_o, bif.bus_rdata_i);
        end
      endcase
    end
    p_ack = ack && busy;
    if (f_now && busy && m_own == 1) m_disc = 1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    bit ic_drop, dc_drop, un_drop, f_now, ack;
    @(negedge clk);
    cyc++;
    ic_drop = 0; dc_drop = 0; un_drop = 0;
    if (ic_seen) begin ic_r = 0; ic_drop = 1; end
    if (dc_seen) begin dc_r = 0; dc_drop = 1; end
    if (un_seen) begin un_r = 0; un_drop = 1; end
    if (!ic_r && !ic_drop && $urandom_range(99) < rate_ic) begin
      ic_r = 1; ic_a = $urandom;
    end
    if (!dc_r && !dc_drop && $urandom_range(99) < rate_dc) begin
      dc_r = 1; dc_a = $urandom; dc_w = 1'($urandom_range(1)); dc_wbase = $urandom;
    end
    if (!un_r && !un_drop && $urandom_range(99) < rate_un) begin
      un_r = 1; un_a = $urandom; un_w = 1'($urandom_range(1)); un_wd = $urandom;
    end
    // bus controller responder
    ack = 0;
    if (bif.bus_req_o) begin
      if (stall > 0) begin
        if (stall_cnt == stall) begin ack = 1; stall_cnt = 0; end
        else stall_cnt++;
      end else begin
        ack = ($urandom_range(99) < ack_pct);
      end
    end else begin
      stall_cnt = 0;
    end
    f_now = flush_n; flush_n = 0;
    bif.ic_req_i = ic_r;  bif.ic_addr_i = ic_a;  bif.ic_flush_i = f_now;
    bif.dc_req_i = dc_r;  bif.dc_addr_i = dc_a;  bif.dc_we_i = dc_w;
    bif.dc_wdata_i = dc_wbase + 32'(bif.ic_beat_o);
    bif.un_req_i = un_r;  bif.un_addr_i = un_a;  bif.un_we_i = un_w;
    bif.un_wdata_i = un_wd;
    bif.bus_ack_i = ack;  bif.bus_rdata_i = $urandom;
    #1;
    model_step(ack, f_now);
    ic_seen = bif.ic_ready_o; dc_seen = bif.dc_ready_o; un_seen = bif.un_ready_o;
    tick_rose = bif.bus_req_o && !prev_req;
    prev_req  = bif.bus_req_o;
    last_ack  = ack;
    arb_reqs  = {p_ic, p_dc, p_un};
    p_ic = ic_r; p_dc = dc_r; p_un = un_r;
  endtask

  task automatic do_reset(input bit now);
    if (now) #1; else @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero();
    ic_r = 0; dc_r = 0; un_r = 0; flush_n = 0;
    rate_ic = 0; rate_dc = 0; rate_un = 0; stall = 0; stall_cnt = 0; ack_pct = 100;
    bif.ic_req_i = 0; bif.dc_req_i = 0; bif.un_req_i = 0; bif.ic_flush_i = 0;
    bif.bus_ack_i = 0; bif.dc_we_i = 0; bif.un_we_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ph = 0; m_own = 0; m_beat = 0; m_age = 0; m_disc = 0;
    p_ic = 0; p_dc = 0; p_un = 0; p_ack = 0;
    ic_seen = 0; dc_seen = 0; un_seen = 0; prev_req = 0;
  endtask

  task automatic drain();
    int n;
    rate_ic = 0; rate_dc = 0; rate_un = 0; ack_pct = 100; stall = 0;
    for (n = 0; n < 200 && (ic_r || dc_r || un_r || m_ph != 0); n++) tick();
    chk1("drain_done", ic_r || dc_r || un_r || m_ph != 0, 1'b0);
  endtask

  // ---------------- vectors: one arbitration from reset ----------------
  typedef struct {
    bit          ic, dc, un;
    logic [1:0]  g;
    logic [31:0] a;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int rv, rdy, acks, first_req, req_cyc, rdy_cyc, last_ack_cyc, lost;
    bit got, found;
    int rise_c[$];
    int rdy_c[$];

    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_1030};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_2000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h4000_0001};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_2000};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd3, 32'h4000_0001};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h4000_0001};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'h4000_0001};

    for (int i = 0; i < 7; i++) begin
      do_reset(0);
      ack_pct = 0;
      ic_a = 32'h0000_1034; dc_a = 32'h0000_2008; dc_w = 0; dc_wbase = 32'h0;
      un_a = 32'h4000_0001; un_w = 0; un_wd = 32'h0;
      ic_r = vecs[i].ic; dc_r = vecs[i].dc; un_r = vecs[i].un;
      tick();
      tick();
      chk("vec_grant", 32'(bif.grant_o), 32'(vecs[i].g));
      chk("vec_addr", bif.bus_addr_o, vecs[i].a);
    end

    // Icache line refill alone, ack every cycle
    do_reset(0);
    ic_a = 32'h0000_1034; ic_r = 1;
    exp_q = {32'h1030, 32'h1034, 32'h1038, 32'h103C};
    req_cyc = cyc + 1; first_req = -1; rv = 0; rdy = 0; rdy_cyc = -1; last_ack_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tick_rose && first_req < 0) first_req = cyc;
      if (last_ack) begin
        if (exp_q.size() > 0) chk("ic_burst_addr", bif.bus_addr_o, exp_q.pop_front());
        last_ack_cyc = cyc;
      end
      if (bif.ic_rvalid_o) rv++;
      if (bif.ic_ready_o) begin rdy++; rdy_cyc = cyc; end
    end
    chk("ic_addr_left", exp_q.size(), 0);
    chk("ic_rvalid_cnt", rv, 4);
    chk("ic_ready_cnt", rdy, 1);
    chk("ic_ready_lat", rdy_cyc, last_ack_cyc + 1);
    chk("ic_first_req", first_req, req_cyc + 1);

    // three simultaneous requests
    do_reset(0);
    ic_a = 32'h0000_1000; dc_a = 32'h0000_2000; dc_w = 0; dc_wbase = 32'h0;
    un_a = 32'h4000_0010; un_w = 0; un_wd = 32'h0;
    ic_r = 1; dc_r = 1; un_r = 1;
    exp_q = {32'd3, 32'd2, 32'd1};
    rise_c.delete(); rdy_c.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tick_rose) begin
        rise_c.push_back(cyc);
        if (exp_q.size() > 0) chk("order", 32'(bif.grant_o), exp_q.pop_front());
      end
      if (bif.ic_ready_o || bif.dc_ready_o || bif.un_ready_o) rdy_c.push_back(cyc);
    end
    chk("order_left", exp_q.size(), 0);
    chk("order_grants", rise_c.size(), 3);
    chk("order_readies", rdy_c.size(), 3);
    if (rise_c.size() == 3 && rdy_c.size() >= 2)
      for (int i = 0; i < 2; i++) chk("order_gap", rise_c[i+1] - rdy_c[i], 2);

    // Dcache write-back with two stall cycles per beat
    do_reset(0);
    stall = 2;
    dc_a = 32'h0000_2000; dc_w = 1; dc_wbase = 32'h0000_00A0; dc_r = 1;
    exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    rv = 0; rdy = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bif.bus_req_o && exp_q.size() > 0) begin
        chk("wb_wdata", bif.bus_wdata_o, exp_q[0]);
        if (last_ack) void'(exp_q.pop_front());
      end
      if (bif.dc_rvalid_o) rv++;
      if (bif.dc_ready_o) rdy++;
    end
    chk("wb_left", exp_q.size(), 0);
    chk("wb_rvalid_cnt", rv, 0);
    chk("wb_ready_cnt", rdy, 1);

    // Icache starvation guard under continuous competing traffic
    do_reset(0);
    ic_a = 32'h0000_3000; ic_r = 1;
    rate_un = 100; rate_dc = 100;
    lost = 0; got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (tick_rose) begin
        if (bif.grant_o == 2'd1) begin
          got = 1;
          chk1("age_contender", arb_reqs[1] | arb_reqs[0], 1'b1);
          chk("age_cleared", 32'(bif.dbg_age_o), 0);
        end else begin
          lost++;
        end
      end
    end
    chk1("age_got", got, 1'b1);
    chk("age_lost", lost, MW);
    drain();

    // jump flush during an Icache burst, then a normal refill
    do_reset(0);
    ic_a = 32'h0000_5000; ic_r = 1;
    acks = 0; rv = 0; rdy = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (last_ack) begin
        acks++;
        if (acks == 2) begin flush_n = 1; ic_r = 0; end
      end
      if (bif.ic_rvalid_o) rv++;
      if (bif.ic_ready_o) rdy++;
    end
    chk("flush_acks", acks, 4);
    chk("flush_rvalid", rv, 2);
    chk("flush_ready", rdy, 0);
    ic_a = 32'h0000_6000; ic_r = 1;
    acks = 0; rv = 0; rdy = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (last_ack) acks++;
      if (bif.ic_rvalid_o) rv++;
      if (bif.ic_ready_o) rdy++;
    end
    chk("after_flush_acks", acks, 4);
    chk("after_flush_rvalid", rv, 4);
    chk("after_flush_ready", rdy, 1);

    // reset in the middle of a Dcache refill
    do_reset(0);
    dc_a = 32'h0000_7000; dc_w = 0; dc_wbase = 32'h0; dc_r = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bif.bus_req_o && bif.ic_beat_o == 2) found = 1;
    end
    chk1("rst_beat2_seen", found, 1'b1);
    do_reset(1);
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_state_idle", 32'(bif.dbg_state_o), 0);
      chk("rst_beat_zero", 32'(bif.ic_beat_o), 0);
      if (bif.dc_ready_o) rdy++;
    end
    chk("rst_no_ready", rdy, 0);

    // randomized traffic
    do_reset(0);
    rate_ic = 30; rate_dc = 30; rate_un = 30; ack_pct = 70;
    for (int i = 0; i < 1500; i++) tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
